// File: rtl/hazard_scoreboard.sv
// Stall/forward unit for the MIPS pipeline. It keeps a per-stage scoreboard
// of pending GRF writes and a countdown for the multi-cycle HI/LO unit, and
// decides whether the D-stage instruction must stall or can take forwarded data.
module hazard_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int REG_AW      = 5,
  parameter int TNEW_W      = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4,
  parameter int SEL_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [TNEW_W-1:0] D_rs_Tuse,
  input  logic [TNEW_W-1:0] D_rt_Tuse,
  input  logic [REG_AW-1:0] D_dst,
  input  logic              D_RegWrite,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              D_mdu_use,
  input  logic              D_mdu_start,
  input  logic              D_mdu_div,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic              mdu_busy
);

  // Scoreboard entries, index 1 is E, index DEPTH is the oldest tracked stage.
  logic [DEPTH:1]             ent_valid;
  logic [DEPTH:1][REG_AW-1:0] ent_dst;
  logic [DEPTH:1][TNEW_W-1:0] ent_tnew;
  logic [CNT_W-1:0]           cnt;

  logic              rs_hit;
  logic              rt_hit;
  logic [SEL_W-1:0]  rs_k;
  logic [SEL_W-1:0]  rt_k;
  logic [TNEW_W-1:0] rs_tnew;
  logic [TNEW_W-1:0] rt_tnew;
  logic              rs_stall;
  logic              rt_stall;
  logic              mdu_stall;

  // Find the youngest matching entry per operand; scanning oldest-first lets
  // younger matches overwrite older ones. Register $0 never matches.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_k    = '0;
    rt_k    = '0;
    rs_tnew = '0;
    rt_tnew = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if ((D_rs != '0) && ent_valid[k] && (ent_dst[k] == D_rs)) begin
        rs_hit  = 1'b1;
        rs_k    = SEL_W'(k);
        rs_tnew = ent_tnew[k];
      end
      if ((D_rt != '0) && ent_valid[k] && (ent_dst[k] == D_rt)) begin
        rt_hit  = 1'b1;
        rt_k    = SEL_W'(k);
        rt_tnew = ent_tnew[k];
      end
    end
  end

  // Stall and forward decisions, purely combinational from state and D inputs.
  always_comb begin
    rs_stall   = rs_hit && (rs_tnew > D_rs_Tuse);
    rt_stall   = rt_hit && (rt_tnew > D_rt_Tuse);
    mdu_stall  = D_mdu_use && (cnt != '0);
    stall      = (rs_stall || rt_stall || mdu_stall) && !flush;
    fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_k : '0;
    fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_k : '0;
    mdu_busy   = (cnt != '0);
  end

  // Advance the scoreboard: flush clears it, a stall injects a bubble into E,
  // otherwise the D instruction enters E. Older entries age by one stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_valid <= '0;
      ent_dst   <= '0;
      ent_tnew  <= '0;
    end else if (flush) begin
      ent_valid <= '0;
    end else begin
      if (stall) begin
        ent_valid[1] <= 1'b0;
        ent_dst[1]   <= '0;
        ent_tnew[1]  <= '0;
      end else begin
        ent_valid[1] <= D_RegWrite;
        ent_dst[1]   <= D_dst;
        ent_tnew[1]  <= D_Tnew;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_dst[k]   <= ent_dst[k-1];
        ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TNEW_W'(1);
      end
    end
  end

  // HI/LO busy countdown; an in-flight mult/div keeps counting through a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (D_mdu_start && !stall && !flush) begin
      cnt <= D_mdu_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table for the
// GRF hazards plus hand-written sequences for MDU, flush and async reset.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_rs_Tuse;
  logic [1:0] D_rt_Tuse;
  logic [4:0] D_dst;
  logic       D_RegWrite;
  logic [1:0] D_Tnew;
  logic       D_mdu_use;
  logic       D_mdu_start;
  logic       D_mdu_div;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       mdu_busy;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic [4:0] rs;
    logic [1:0] rs_tuse;
    logic [4:0] rt;
    logic [1:0] rt_tuse;
    logic [4:0] dst;
    logic       rw;
    logic [1:0] tnew;
    logic       e_stall;
    logic [1:0] e_rs;
    logic [1:0] e_rt;
  } vec_t;

  vec_t vecs[13];

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_Tuse  (D_rs_Tuse),
    .D_rt_Tuse  (D_rt_Tuse),
    .D_dst      (D_dst),
    .D_RegWrite (D_RegWrite),
    .D_Tnew     (D_Tnew),
    .D_mdu_use  (D_mdu_use),
    .D_mdu_start(D_mdu_start),
    .D_mdu_div  (D_mdu_div),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .mdu_busy   (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] rs_tuse,
                              input logic [4:0] rt, input logic [1:0] rt_tuse,
                              input logic [4:0] dst, input logic rw, input logic [1:0] tnew,
                              input logic e_stall, input logic [1:0] e_rs, input logic [1:0] e_rt);
    vec_t v;
    v.rs = rs; v.rs_tuse = rs_tuse; v.rt = rt; v.rt_tuse = rt_tuse;
    v.dst = dst; v.rw = rw; v.tnew = tnew;
    v.e_stall = e_stall; v.e_rs = e_rs; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    D_rs        = v.rs;
    D_rs_Tuse   = v.rs_tuse;
    D_rt        = v.rt;
    D_rt_Tuse   = v.rt_tuse;
    D_dst       = v.dst;
    D_RegWrite  = v.rw;
    D_Tnew      = v.tnew;
    D_mdu_use   = 1'b0;
    D_mdu_start = 1'b0;
    D_mdu_div   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic setMdu(input logic use_i, input logic start_i, input logic div_i);
    D_mdu_use   = use_i;
    D_mdu_start = start_i;
    D_mdu_div   = div_i;
  endtask

  task automatic checkOne(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_stall,
                             input logic [1:0] e_rs, input logic [1:0] e_rt,
                             input logic e_busy);
    checkOne({name, ".stall"}, int'(stall), int'(e_stall));
    checkOne({name, ".fwd_rs"}, int'(fwd_rs_sel), int'(e_rs));
    checkOne({name, ".fwd_rt"}, int'(fwd_rt_sel), int'(e_rt));
    checkOne({name, ".busy"}, int'(mdu_busy), int'(e_busy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
      step();
    end
  endtask

  task automatic mflo();
    applyStimulus(mk(0,0,0,0,8,1,1,0,0,0));
    setMdu(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bit drained;

    //           rs t  rt t  dst rw tn  st frs frt
    vecs[0]  = mk(0,0, 0,0, 2, 1, 2,  0, 0, 0);
    vecs[1]  = mk(2,1, 0,0, 5, 1, 1,  1, 0, 0);
    vecs[2]  = mk(2,1, 0,0, 5, 1, 1,  0, 0, 0);
    vecs[3]  = mk(2,1, 0,0, 0, 0, 0,  0, 3, 0);
    vecs[4]  = mk(0,0, 0,0, 3, 1, 1,  0, 0, 0);
    vecs[5]  = mk(5,0, 3,0, 0, 0, 0,  1, 3, 0);
    vecs[6]  = mk(5,0, 3,0, 0, 0, 0,  0, 0, 2);
    vecs[7]  = mk(0,0, 0,0, 4, 1, 2,  0, 0, 0);
    vecs[8]  = mk(0,0, 0,0, 4, 1, 0,  0, 0, 0);
    vecs[9]  = mk(4,0, 4,0, 0, 0, 0,  0, 1, 1);
    vecs[10] = mk(0,0, 4,0, 0, 0, 0,  0, 0, 2);
    vecs[11] = mk(0,0, 0,0, 0, 1, 2,  0, 0, 0);
    vecs[12] = mk(0,0, 0,0, 0, 0, 0,  0, 0, 0);

    // Reset state with busy-looking D inputs.
    reset = 1'b0;
    applyStimulus(mk(2,0,3,0,2,1,2,0,0,0));
    setMdu(1'b1, 1'b0, 1'b0);
    #3;
    checkOutput("reset", 0, 0, 0, 0);
    #9;
    reset = 1'b1;

    // Cycle-by-cycle GRF hazard table.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_rs, vecs[i].e_rt, 1'b0);
      step();
    end
    nops(3);

    // div: mflo waits exactly 10 cycles.
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
    setMdu(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("div_issue", 0, 0, 0, 0);
    step();
    mflo();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("div_wait%0d", i), 1, 0, 0, 1);
      step();
    end
    @(negedge clk);
    checkOutput("div_done", 0, 0, 0, 0);
    step();

    // mult: mflo waits exactly 5 cycles.
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
    setMdu(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("mult_issue", 0, 0, 0, 0);
    step();
    mflo();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mult_wait%0d", i), 1, 0, 0, 1);
      step();
    end
    @(negedge clk);
    checkOutput("mult_done", 0, 0, 0, 0);
    step();
    nops(3);

    // Flush during a load-use stall with a div in flight.
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
    setMdu(1'b1, 1'b1, 1'b1);
    step();
    applyStimulus(mk(0,0,0,0,2,1,2,0,0,0));
    @(negedge clk);
    checkOutput("fl_lw", 0, 0, 0, 1);
    step();
    applyStimulus(mk(2,1,0,0,0,0,0,0,0,0));
    @(negedge clk);
    checkOutput("fl_stall", 1, 0, 0, 1);
    flush = 1'b1;
    #1;
    checkOutput("fl_flush", 0, 0, 0, 1);
    step();
    applyStimulus(mk(2,0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    checkOutput("fl_after", 0, 0, 0, 1);
    setMdu(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("fl_cnt_kept", 1, 0, 0, 1);
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      step();
      if (!mdu_busy) drained = 1'b1;
    end
    checkOne("fl_drain", int'(drained), 1);
    nops(3);

    // Async reset mid-div with cnt=6 and a load in E.
    applyStimulus(mk(0,0,0,0,0,0,0,0,0,0));
    setMdu(1'b1, 1'b1, 1'b1);
    step();
    nops(3);
    applyStimulus(mk(0,0,0,0,2,1,2,0,0,0));
    step();
    applyStimulus(mk(2,0,0,0,0,0,0,0,0,0));
    setMdu(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_before", 1, 0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_async", 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    applyStimulus(mk(0,0,0,0,2,1,2,0,0,0));
    step();
    applyStimulus(mk(2,1,0,0,0,0,0,0,0,0));
    @(negedge clk);
    checkOutput("rst_lw_stall", 1, 0, 0, 0);
    step();
    @(negedge clk);
    checkOutput("rst_lw_m", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised stall/forward unit for the MIPS pipeline; replaces the fixed E/M Tnew outputs of the decoder with a per-stage scoreboard.
- Holds destination register, write flag and Tnew countdown for each stage after D.
- Compares these against the D-stage operands and their Tuse values, and drives stall plus D-stage forwarding selects.
- Also tracks the multi-cycle HI/LO unit and stalls D-stage MDU instructions while it is busy.

Parameters:
DEPTH, 3, number of tracked stages after D (1=E, 2=M, 3=W, ...)
REG_AW, 5, register address width
TNEW_W, 2, width of Tnew/Tuse fields
MULT_CYCLES, 5, busy cycles loaded for mult/multu
DIV_CYCLES, 10, busy cycles loaded for div/divu
CNT_W, 4, MDU busy counter width (must hold DIV_CYCLES)
SEL_W, 2, forward select width, $clog2(DEPTH+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline clear (exception/eret)
D_rs  in  REG_AW  D-stage rs address
D_rt  in  REG_AW  D-stage rt address
D_rs_Tuse  in  TNEW_W  cycles until rs is consumed
D_rt_Tuse  in  TNEW_W  cycles until rt is consumed
D_dst  in  REG_AW  D-stage destination register
D_RegWrite  in  1  D instruction writes GRF
D_Tnew  in  TNEW_W  Tnew the instruction carries on entering E
D_mdu_use  in  1  D instruction is any HI/LO access (mult..mflo)
D_mdu_start  in  1  D instruction is mult/multu/div/divu
D_mdu_div  in  1  with start: 1=div/divu, 0=mult/multu
stall  out  1  freeze PC and F/D, insert bubble into E
fwd_rs_sel  out  SEL_W  0=GRF, k=forward from stage k
fwd_rt_sel  out  SEL_W  same for rt
mdu_busy  out  1  MDU counter non-zero

Behaviour:
- State: DEPTH entries {valid, dst, tnew} (entry 1 = E) plus MDU counter cnt.
- Reset (reset=0, asynchronous): every entry valid=0, dst=0, tnew=0; cnt=0. Consequently stall=0, fwd_rs_sel=0, fwd_rt_sel=0, mdu_busy=0 regardless of D inputs, except stall from an MDU request, which is also 0 because cnt=0.
- Match for an operand addr: addr != 0 and entry k valid and dst_k == addr. Only the lowest-k (youngest) match counts; older matches are ignored.
- Data stall: youngest match has tnew_k > Tuse of that operand.
- MDU stall: D_mdu_use and cnt != 0.
- stall = (rs data stall | rt data stall | MDU stall) and not flush. All outputs are combinational from state and D inputs; zero-cycle decision.
- Forward select = k when the youngest match has tnew_k == 0; otherwise 0.
- Per clock edge, in priority order:
  - flush=1: all entries become invalid; cnt is kept, because an in-flight mult/div completes.
  - stall=1: entry 1 <= bubble (valid=0); entries k>1 <= entry k-1 with tnew decremented, saturating at 0.
  - Otherwise: entry 1 <= {D_RegWrite, D_dst, D_Tnew}; entries k>1 shift as above.
  - The entry leaving stage DEPTH is dropped.
- Entries are valid only when the write flag is set; RegWrite=0 instructions enter as valid=0.
- MDU counter:
  - Loaded with DIV_CYCLES or MULT_CYCLES when D_mdu_start, no stall and no flush. The counter is non-zero the cycle the op sits in E.
  - Otherwise decrements when non-zero.
  - mthi/mtlo/mfhi/mflo use D_mdu_use only; they do not load cnt.
- Register $0 never stalls or forwards.
- Two operands may match different stages; each is evaluated independently.

Test Plan:
- Load-use: lw $2 (D_Tnew=2) enters E; next D is add with rs=$2, Tuse=1. Required: stall=1 for one cycle and fwd_rs_sel=0. Next cycle (lw in M, tnew=1): stall=0. Cycle after (lw in W, tnew=0) with a D reader of $2: fwd_rs_sel=3.
- ALU forward: addu $3 (D_Tnew=1) in E; D beq rt=$3, Tuse=0 -> stall=1. Next cycle (M, tnew=0) -> stall=0, fwd_rt_sel=2.
- Youngest wins: $4 written by E entry (tnew=0) and M entry; D reads $4 -> fwd_rs_sel=1. Same with rs=$0 -> fwd_rs_sel=0, stall=0.
- MDU: div issued (no stall) -> cnt=10 next cycle, mdu_busy=1. mflo held in D -> stall=1 for exactly 10 cycles, then 0. Repeat with mult -> 5 cycles.
- Flush during load-use stall: flush=1 -> stall=0 that cycle; next cycle all entries invalid, so a D reader of $2 gets stall=0 and fwd=0; cnt unaffected.
- Async reset asserted mid-div (cnt=6) between clock edges: outputs immediately 0 and mdu_busy=0; after release, first instruction enters E normally.
